// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: owns PC, IR, NZCV flags and the fetch/data-memory handshakes,
// and gates the register-file, flag and data-memory write enables of a combinational ARM datapath.
module cpu_sequencer #(
  parameter int DATA_W  = 32,
  parameter int PC_W    = 8,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              halt_in,
  output logic              instr_req_out,
  output logic [PC_W-1:0]   instr_addr_out,
  input  logic [31:0]       instr_rdata_in,
  input  logic              instr_ack_in,
  output logic [31:0]       ir_out,
  input  logic              cond_pass_in,
  input  logic              is_branch_in,
  input  logic              is_mem_in,
  input  logic              is_store_in,
  input  logic              rf_wr_in,
  input  logic              flag_wr_in,
  input  logic [3:0]        alu_flags_in,
  input  logic [DATA_W-1:0] alu_result_in,
  output logic              dmem_req_out,
  output logic              dmem_we_out,
  output logic [ADDR_W-1:0] dmem_addr_out,
  input  logic              dmem_ack_in,
  output logic              rf_we_out,
  output logic              rf_src_mem_out,
  output logic [3:0]        flags_out,
  output logic [PC_W-1:0]   pc_out,
  output logic [PC_W-1:0]   r15_out,
  output logic              retired_out,
  output logic [CNT_W-1:0]  retired_cnt_out,
  output logic              fault_out
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEM   = 2'd2,
    S_FAULT = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [31:0]        ir_q;
  logic [3:0]         flags_q;
  logic [ADDR_W-1:0]  dmem_addr_q;
  logic               store_q;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               pending_q, pending_d;
  logic               retired_q;
  logic [CNT_W-1:0]   retired_cnt_q;

  logic fetch_req;
  logic wait_expired;
  logic ir_we;
  logic flags_we;
  logic dmem_cap;
  logic retire;
  logic rf_we;

  // Only the low bits of the ALU result address PC / data memory; the rest is intentionally dropped.
  logic unused_alu;
  assign unused_alu = ^alu_result_in;

  // Gating with the reset pin makes the fetch request drop asynchronously, like the state-derived outputs.
  assign fetch_req    = rst_n_in && (state_q == S_FETCH) && (pending_q || !halt_in);
  assign wait_expired = (wait_q == WAIT_W'(TIMEOUT - 1));

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    wait_d    = wait_q;
    pending_d = 1'b0;
    ir_we     = 1'b0;
    flags_we  = 1'b0;
    dmem_cap  = 1'b0;
    retire    = 1'b0;
    rf_we     = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        if (fetch_req) begin
          if (instr_ack_in) begin
            ir_we   = 1'b1;
            wait_d  = '0;
            state_d = S_EXEC;
          end else if (wait_expired) begin
            state_d = S_FAULT;
          end else begin
            wait_d    = wait_q + 1'b1;
            pending_d = 1'b1;
          end
        end
      end

      S_EXEC: begin
        state_d = S_FETCH;
        wait_d  = '0;
        pc_d    = pc_q + PC_W'(4);
        if (!cond_pass_in) begin
          retire = 1'b1;
        end else if (is_branch_in) begin
          retire = 1'b1;
          pc_d   = alu_result_in[PC_W-1:0] & ~PC_W'(3);
        end else if (is_mem_in) begin
          dmem_cap = 1'b1;
          pc_d     = pc_q;
          state_d  = S_MEM;
        end else begin
          retire   = 1'b1;
          rf_we    = rf_wr_in;
          flags_we = flag_wr_in;
        end
      end

      S_MEM: begin
        if (dmem_ack_in) begin
          rf_we   = !store_q;
          retire  = 1'b1;
          pc_d    = pc_q + PC_W'(4);
          wait_d  = '0;
          state_d = S_FETCH;
        end else if (wait_expired) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      S_FAULT: begin
        state_d = S_FAULT;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= S_FETCH;
      pc_q      <= '0;
      wait_q    <= '0;
      pending_q <= 1'b0;
      retired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      wait_q    <= wait_d;
      pending_q <= pending_d;
      retired_q <= retire;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ir_q        <= '0;
      flags_q     <= '0;
      dmem_addr_q <= '0;
      store_q     <= 1'b0;
    end else begin
      if (ir_we) begin
        ir_q <= instr_rdata_in;
      end
      if (flags_we) begin
        flags_q <= alu_flags_in;
      end
      if (dmem_cap) begin
        dmem_addr_q <= alu_result_in[ADDR_W-1:0];
        store_q     <= is_store_in;
      end
    end
  end

  // Retired-instruction counter sticks at all-ones instead of wrapping.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      retired_cnt_q <= '0;
    end else if (retire && (retired_cnt_q != '1)) begin
      retired_cnt_q <= retired_cnt_q + 1'b1;
    end
  end

  assign instr_req_out   = fetch_req;
  assign instr_addr_out  = pc_q;
  assign ir_out          = ir_q;
  assign dmem_req_out    = (state_q == S_MEM);
  assign dmem_we_out     = (state_q == S_MEM) && store_q;
  assign dmem_addr_out   = dmem_addr_q;
  assign rf_we_out       = rf_we;
  assign rf_src_mem_out  = (state_q == S_MEM) && !store_q;
  assign flags_out       = flags_q;
  assign pc_out          = pc_q;
  assign r15_out         = pc_q + PC_W'(8);
  assign retired_out     = retired_q;
  assign retired_cnt_out = retired_cnt_q;
  assign fault_out       = (state_q == S_FAULT);

endmodule
